// File: rtl/sram_link_pkg.sv
// Shared types and constants for the byte-serial SRAM command link.
//   state_e    : initiator FSM states
//   CMD_RD_BIT : command byte bit that marks a read
//   make_cmd() : builds the command byte from direction and word address
package sram_link_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StWrB,
    StRdB,
    StRsp
  } state_e;

  localparam int unsigned CMD_RD_BIT     = 5;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;

  function automatic logic [7:0] make_cmd(input logic we, input logic [4:0] addr);
    logic [7:0] cmd;
    cmd             = {3'b000, addr};
    cmd[CMD_RD_BIT] = ~we;
    return cmd;
  endfunction

endpackage

// File: rtl/sram_link_if.sv
// Request/response, outbound byte link and inbound byte link of the SRAM link initiator.
//   master modport : the initiator (sram_link_master)
//   slave modport  : the host plus both byte links seen from outside
interface sram_link_if
  import sram_link_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              wr_done;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        tx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [7:0]        rx_data;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, tx_ready, rx_valid, rx_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, wr_done, tx_valid, tx_data, rx_ready
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, tx_ready, rx_valid, rx_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, wr_done, tx_valid, tx_data, rx_ready
  );
endinterface

// File: rtl/sram_link_timer.sv
// Read-response timeout counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force count to zero (takes priority over run)
//   run        : advance count by one per cycle
//   expire     : count has reached LIMIT-1 while running
module sram_link_timer #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expire
);
  localparam int unsigned CntW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire = run && (cnt_q == CntW'(LIMIT - 1));
endmodule

// File: rtl/sram_link_master.sv
// Host-side initiator for the byte-serial SRAM command link. Serialises one 32-bit read/write
// request into a command byte (+4 data bytes MSB first for writes) and, for reads, gathers
// 4 response bytes LSB first into rsp_rdata. Every output is a register.
//   clk, rst_n : clock, asynchronous active-low reset (aborts any transaction)
//   link       : sram_link_if.master (request, response, tx byte link, rx byte link)
// Optional feature: define SRAM_LINK_TIMEOUT_EN to give up on a silent read after
// TIMEOUT_CYCLES cycles and return the partial word with rsp_err set.
module sram_link_master
  import sram_link_pkg::*;
#(
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  sram_link_if.master     link
);
  localparam logic [1:0] LastByte = 2'(BYTES_PER_WORD - 1);

  if (ADDR_W == 0 || ADDR_W > 5) begin : g_addr_w_check
    $error("sram_link_master: ADDR_W must be 1..5");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("sram_link_master: TIMEOUT_CYCLES must be at least 2");
  end

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              wr_done_q, wr_done_d;
  logic              req_ready_q, req_ready_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              rx_ready_q, rx_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              timeout;

  logic req_hs, tx_hs, rx_hs;
  assign req_hs = link.req_valid & req_ready_q;
  assign tx_hs  = tx_valid_q & link.tx_ready;
  assign rx_hs  = link.rx_valid & rx_ready_q;

`ifdef SRAM_LINK_TIMEOUT_EN
  logic err_q, err_d;

  // Idle outside RD_B, so the count restarts on entry and after every received byte.
  sram_link_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  ((state_q != StRdB) || rx_hs),
    .run    (state_q == StRdB),
    .expire (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign link.rsp_err = err_q;
`else
  assign timeout      = 1'b0;
  assign link.rsp_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    wr_done_d = 1'b0;
`ifdef SRAM_LINK_TIMEOUT_EN
    err_d     = err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (req_hs) begin
          we_d    = link.req_we;
          addr_d  = link.req_addr;
          wdata_d = link.req_wdata;
          state_d = StCmd;
        end
      end
      StCmd: begin
        if (tx_hs) begin
          cnt_d = '0;
          if (we_q) begin
            state_d = StWrB;
          end else begin
            state_d = StRdB;
            rdata_d = '0;
          end
        end
      end
      StWrB: begin
        if (tx_hs) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == LastByte) begin
            state_d   = StIdle;
            wr_done_d = 1'b1;
          end
        end
      end
      StRdB: begin
        // A byte arriving in the expiry cycle wins over the timeout.
        if (rx_hs) begin
          rdata_d[{cnt_q, 3'b000} +: 8] = link.rx_data;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == LastByte) state_d = StRsp;
        end else if (timeout) begin
          state_d = StRsp;
`ifdef SRAM_LINK_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end
      end
      StRsp: begin
        if (link.rsp_ready) begin
          state_d = StIdle;
`ifdef SRAM_LINK_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so they are registered yet cycle-accurate.
    req_ready_d = (state_d == StIdle);
    tx_valid_d  = (state_d == StCmd) || (state_d == StWrB);
    rx_ready_d  = (state_d == StRdB);
    rsp_valid_d = (state_d == StRsp);
    tx_data_d   = '0;
    if (state_d == StCmd) begin
      tx_data_d = make_cmd(we_d, 5'(addr_d));
    end else if (state_d == StWrB) begin
      // ~cnt selects byte 3-cnt: payload goes out MSB first.
      tx_data_d = wdata_d[{~cnt_d, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      wr_done_q   <= 1'b0;
      req_ready_q <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      rx_ready_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      wr_done_q   <= wr_done_d;
      req_ready_q <= req_ready_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      rx_ready_q  <= rx_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign link.req_ready = req_ready_q;
  assign link.tx_valid  = tx_valid_q;
  assign link.tx_data   = tx_data_q;
  assign link.rx_ready  = rx_ready_q;
  assign link.rsp_valid = rsp_valid_q;
  assign link.rsp_rdata = rdata_q;
  assign link.wr_done   = wr_done_q;
endmodule

// File: tb/tb_sram_link_master.sv
// Directed self-checking bench for sram_link_master (DUT built with TIMEOUT_CYCLES=16).
module tb_sram_link_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_link_if #(.ADDR_W(5)) link ();

  sram_link_master #(
    .ADDR_W         (5),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .link  (link)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] tx_q[$];
  int rx_hs_cnt = 0;
  int wr_done_cnt = 0;

  // Link-side monitor: bytes accepted on tx, rx handshakes, wr_done pulses.
  always @(posedge clk) begin
    if (rst_n) begin
      if (link.tx_valid && link.tx_ready) tx_q.push_back(link.tx_data);
      if (link.rx_valid && link.rx_ready) rx_hs_cnt++;
      if (link.wr_done) wr_done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] tx_at(input int i);
    if (i < tx_q.size()) return tx_q[i];
    return 8'hxx;
  endfunction

  task automatic do_req(input logic we, input logic [4:0] addr, input logic [31:0] wdata);
    bit ok = 1'b0;
    link.req_valid = 1'b1;
    link.req_we    = we;
    link.req_addr  = addr;
    link.req_wdata = wdata;
    for (int i = 0; i < 20; i++) begin
      if (link.req_ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    link.req_valid = 1'b0;
    if (!ok) check("req handshake", {31'b0, ok}, 32'd1);
  endtask

  task automatic send_rx(input logic [7:0] b);
    bit ok = 1'b0;
    link.rx_valid = 1'b1;
    link.rx_data  = b;
    for (int i = 0; i < 20; i++) begin
      if (link.rx_ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    link.rx_valid = 1'b0;
    if (!ok) check("rx handshake", {31'b0, ok}, 32'd1);
  endtask

  task automatic consume_rsp();
    link.rsp_ready = 1'b1;
    tick();
    link.rsp_ready = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " req_ready"}, link.req_ready, 0);
    check({tag, " tx_valid"}, link.tx_valid, 0);
    check({tag, " tx_data"}, link.tx_data, 0);
    check({tag, " rx_ready"}, link.rx_ready, 0);
    check({tag, " rsp_valid"}, link.rsp_valid, 0);
    check({tag, " rsp_rdata"}, link.rsp_rdata, 0);
    check({tag, " rsp_err"}, link.rsp_err, 0);
    check({tag, " wr_done"}, link.wr_done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  pd;
    logic        pv, pr;
    logic [31:0] held;
    int          base, k;

    link.req_valid = 1'b0;
    link.req_we    = 1'b0;
    link.req_addr  = '0;
    link.req_wdata = '0;
    link.rsp_ready = 1'b0;
    link.tx_ready  = 1'b1;
    link.rx_valid  = 1'b0;
    link.rx_data   = '0;

    // Reset state
    tick();
    tick();
    check_quiet("reset");
    rst_n = 1'b1;
    tick();
    check("idle req_ready", link.req_ready, 1);

    // 1. Write 0x0A <- DEADBEEF, link always ready
    tx_q.delete();
    wr_done_cnt = 0;
    do_req(1'b1, 5'h0A, 32'hDEADBEEF);
    check("t1 tx_valid", link.tx_valid, 1);
    check("t1 cmd byte", link.tx_data, 8'h0A);
    check("t1 req_ready busy", link.req_ready, 0);
    repeat (5) tick();
    check("t1 byte count", tx_q.size(), 5);
    check("t1 byte0", tx_at(0), 8'h0A);
    check("t1 byte1", tx_at(1), 8'hDE);
    check("t1 byte2", tx_at(2), 8'hAD);
    check("t1 byte3", tx_at(3), 8'hBE);
    check("t1 byte4", tx_at(4), 8'hEF);
    check("t1 wr_done", link.wr_done, 1);
    check("t1 req_ready back", link.req_ready, 1);
    check("t1 tx_valid idle", link.tx_valid, 0);
    tick();
    check("t1 wr_done drop", link.wr_done, 0);
    check("t1 wr_done pulses", wr_done_cnt, 1);

    // 2. Read 0x03, response 11 22 33 44
    tx_q.delete();
    do_req(1'b0, 5'h03, 32'h0);
    check("t2 cmd byte", link.tx_data, 8'h23);
    tick();
    check("t2 tx count", tx_q.size(), 1);
    check("t2 tx byte", tx_at(0), 8'h23);
    check("t2 rx_ready", link.rx_ready, 1);
    send_rx(8'h11);
    send_rx(8'h22);
    send_rx(8'h33);
    check("t2 rsp_valid early", link.rsp_valid, 0);
    send_rx(8'h44);
    check("t2 rsp_valid", link.rsp_valid, 1);
    check("t2 rsp_rdata", link.rsp_rdata, 32'h44332211);
    check("t2 rsp_err", link.rsp_err, 0);
    check("t2 rx_ready off", link.rx_ready, 0);
    consume_rsp();
    check("t2 rsp_valid drop", link.rsp_valid, 0);
    check("t2 req_ready", link.req_ready, 1);
    check("t2 rdata held", link.rsp_rdata, 32'h44332211);

    // 4. Response back-pressure with a stray rx byte
    tx_q.delete();
    do_req(1'b0, 5'h1F, 32'h0);
    tick();
    check("t4 cmd byte", tx_at(0), 8'h3F);
    check("t4 rdata cleared", link.rsp_rdata, 0);
    send_rx(8'h01);
    send_rx(8'h02);
    send_rx(8'h03);
    send_rx(8'h04);
    link.rx_valid = 1'b1;
    link.rx_data  = 8'h99;
    base = rx_hs_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("t4 rsp_valid %0d", i), link.rsp_valid, 1);
      check($sformatf("t4 rdata %0d", i), link.rsp_rdata, 32'h04030201);
      check($sformatf("t4 req_ready %0d", i), link.req_ready, 0);
      check($sformatf("t4 rx_ready %0d", i), link.rx_ready, 0);
    end
    check("t4 stray not taken", rx_hs_cnt - base, 0);
    link.rx_valid = 1'b0;
    consume_rsp();
    check("t4 rsp_valid drop", link.rsp_valid, 0);

    // 3. Write with tx_ready toggling
    tx_q.delete();
    wr_done_cnt = 0;
    link.tx_ready = 1'b0;
    do_req(1'b1, 5'h15, 32'hCAFEF00D);
    for (int i = 0; i < 24; i++) begin
      pv = link.tx_valid;
      pd = link.tx_data;
      pr = link.tx_ready;
      tick();
      if (pv && !pr) begin
        check($sformatf("t3 stall valid %0d", i), link.tx_valid, 1);
        check($sformatf("t3 stall data %0d", i), link.tx_data, pd);
      end
      link.tx_ready = ~link.tx_ready;
    end
    link.tx_ready = 1'b1;
    check("t3 byte count", tx_q.size(), 5);
    check("t3 byte0", tx_at(0), 8'h15);
    check("t3 byte1", tx_at(1), 8'hCA);
    check("t3 byte2", tx_at(2), 8'hFE);
    check("t3 byte3", tx_at(3), 8'hF0);
    check("t3 byte4", tx_at(4), 8'h0D);
    check("t3 wr_done pulses", wr_done_cnt, 1);
    check("t3 req_ready", link.req_ready, 1);

    // 5. Reset after the second write data byte
    tx_q.delete();
    wr_done_cnt = 0;
    do_req(1'b1, 5'h07, 32'h12345678);
    repeat (3) tick();
    check("t5 bytes before reset", tx_q.size(), 3);
    rst_n = 1'b0;
    tick();
    check_quiet("t5 in reset");
    tick();
    check("t5 no bytes in reset", tx_q.size(), 3);
    check("t5 no wr_done", wr_done_cnt, 0);
    rst_n = 1'b1;
    tick();
    tx_q.delete();
    do_req(1'b0, 5'h02, 32'h0);
    repeat (6) tick();
    check("t5 read tx count", tx_q.size(), 1);
    check("t5 read cmd", tx_at(0), 8'h22);
    send_rx(8'h5A);
    send_rx(8'hA5);
    send_rx(8'h0F);
    send_rx(8'hF0);
    check("t5 rsp_rdata", link.rsp_rdata, 32'hF00FA55A);
    check("t5 rsp_err", link.rsp_err, 0);
    consume_rsp();

`ifdef SRAM_LINK_TIMEOUT_EN
    // 6. Timeout after a single byte
    do_req(1'b0, 5'h04, 32'h0);
    tick();
    send_rx(8'hAA);
    k = 0;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (link.rsp_valid) begin
        k = i;
        break;
      end
    end
    check("t6 timeout latency", k, 16);
    check("t6 rsp_err", link.rsp_err, 1);
    check("t6 partial rdata", link.rsp_rdata, 32'h000000AA);
    check("t6 rx_ready off", link.rx_ready, 0);
    consume_rsp();
    check("t6 rsp_err clear", link.rsp_err, 0);
`else
    // 6. Without the timeout a silent read waits indefinitely
    do_req(1'b0, 5'h04, 32'h0);
    tick();
    send_rx(8'hAA);
    repeat (40) tick();
    check("t6 still waiting", link.rsp_valid, 0);
    check("t6 rx_ready", link.rx_ready, 1);
    send_rx(8'hBB);
    send_rx(8'hCC);
    send_rx(8'hDD);
    check("t6 rsp_rdata", link.rsp_rdata, 32'hDDCCBBAA);
    check("t6 rsp_err", link.rsp_err, 0);
    consume_rsp();
`endif
    held = link.rsp_rdata;
    tick();
    check("final idle", link.req_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
